// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment encoder/decoder pair.
//   SEG_*      : active-high segment patterns, bit order {a,b,c,d,e,f,g}
//   BCD_BLANK  : code reported for an all-off (blank) digit
//   BCD_ERR    : code reported for an unrecognised pattern
//   state_e    : frame collector state
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam logic [3:0] BCD_BLANK = 4'hA;
   localparam logic [3:0] BCD_ERR   = 4'hF;

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      PRESENT = 1'b1
   } state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment pattern to BCD decoder.
//   seg : pattern {a,b,c,d,e,f,g}, active high
//   bcd : 0..9, BCD_BLANK for an all-off digit, BCD_ERR otherwise
//   err : high when the pattern is not a digit and not blank
module seg7_to_bcd
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] bcd,
   output logic       err
);

   always_comb begin
      bcd = BCD_ERR;
      err = 1'b1;
      case (seg)
         SEG_0:     begin bcd = 4'd0;      err = 1'b0; end
         SEG_1:     begin bcd = 4'd1;      err = 1'b0; end
         SEG_2:     begin bcd = 4'd2;      err = 1'b0; end
         SEG_3:     begin bcd = 4'd3;      err = 1'b0; end
         SEG_4:     begin bcd = 4'd4;      err = 1'b0; end
         SEG_5:     begin bcd = 4'd5;      err = 1'b0; end
         SEG_6:     begin bcd = 4'd6;      err = 1'b0; end
         SEG_7:     begin bcd = 4'd7;      err = 1'b0; end
         SEG_8:     begin bcd = 4'd8;      err = 1'b0; end
         SEG_9:     begin bcd = 4'd9;      err = 1'b0; end
         SEG_BLANK: begin bcd = BCD_BLANK; err = 1'b0; end
         default:   begin bcd = BCD_ERR;   err = 1'b1; end
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Reconstructs a multi-digit BCD value from a multiplexed 7-segment bus.
// A digit is accepted once its strobe and pattern have been steady for
// STABLE_CYCLES samples; when every digit has been accepted the frame is
// offered on a valid/ready interface.
//   clk, rst  : clock, synchronous active-high reset
//   seg       : segment pattern {a,b,c,d,e,f,g}, active high
//   dig_en    : one-hot digit strobe, bit i selects digit i
//   out_bcd   : frame value, digit i in [4i+3:4i]
//   out_err   : per-digit unrecognised-pattern flags
//   out_valid : frame available
//   out_ready : consumer accepts the frame
//   overrun   : one-cycle pulse when a completed frame is dropped
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 3
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [6:0]              seg,
   input  logic [NUM_DIGITS-1:0]   dig_en,
   output logic [4*NUM_DIGITS-1:0] out_bcd,
   output logic [NUM_DIGITS-1:0]   out_err,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    overrun
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 1);
   localparam bit SINGLE = (STABLE_CYCLES == 1);

   // live decode of the bus
   logic [3:0] dec_bcd;
   logic       dec_err;

   seg7_to_bcd u_dec (
      .seg (seg),
      .bcd (dec_bcd),
      .err (dec_err)
   );

   state_e                         state_q;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic [IDX_W-1:0]               ref_idx_q, idx;
   logic [6:0]                     ref_seg_q;
   logic [NUM_DIGITS-1:0]          seen_q;
   logic [NUM_DIGITS-1:0][3:0]     dig_q, dig_d;
   logic [NUM_DIGITS-1:0]          err_q, err_d;
   logic [NUM_DIGITS-1:0][3:0]     out_bcd_q;
   logic [NUM_DIGITS-1:0]          out_err_q;
   logic                           overrun_q;
   logic                           onehot, match, capture, frame_done;

   always_comb begin
      idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (dig_en[i]) idx = IDX_W'(i);
   end

   always_comb begin
      onehot = $onehot(dig_en);
      // cnt_q == 0 means the previous sample was not a usable reference
      match  = onehot && (cnt_q != '0) && (idx == ref_idx_q) && (seg == ref_seg_q);

      if (!onehot)
         cnt_d = '0;
      else if (match)
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      else
         cnt_d = CNT_W'(1);

      // Fires only on the transition into saturation, so a held digit is
      // captured exactly once. With a single-sample requirement, every new
      // reference captures instead.
      capture    = onehot && (match ? (cnt_q == CNT_PRE && !SINGLE) : SINGLE);
      frame_done = capture && (&(seen_q | dig_en));

      // digit registers including the digit being captured this cycle, so a
      // completing frame can be presented without an extra cycle
      dig_d = dig_q;
      err_d = err_q;
      if (capture) begin
         dig_d[idx] = dec_bcd;
         err_d[idx] = dec_err;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= COLLECT;
         cnt_q     <= '0;
         ref_idx_q <= '0;
         ref_seg_q <= '0;
         seen_q    <= '0;
         dig_q     <= '0;
         err_q     <= '0;
         out_bcd_q <= '0;
         out_err_q <= '0;
         overrun_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         dig_q     <= dig_d;
         err_q     <= err_d;
         overrun_q <= 1'b0;

         if (onehot && !match) begin
            ref_idx_q <= idx;
            ref_seg_q <= seg;
         end

         if (frame_done)
            seen_q <= '0;
         else if (capture)
            seen_q <= seen_q | dig_en;

         case (state_q)
            COLLECT: begin
               if (frame_done) begin
                  out_bcd_q <= dig_d;
                  out_err_q <= err_d;
                  state_q   <= PRESENT;
               end
            end
            PRESENT: begin
               if (frame_done) begin
                  // a frame landing on the handshake cycle replaces the old one
                  if (out_ready) begin
                     out_bcd_q <= dig_d;
                     out_err_q <= err_d;
                  end else begin
                     overrun_q <= 1'b1;
                  end
               end else if (out_ready) begin
                  state_q <= COLLECT;
               end
            end
            default: state_q <= COLLECT;
         endcase
      end
   end

   assign out_bcd   = out_bcd_q;
   assign out_err   = out_err_q;
   assign out_valid = (state_q == PRESENT);
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
module tb_seg7_scan_decoder;
   import seg7_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  seg;
   logic [3:0]  dig_en;
   logic [15:0] out_bcd;
   logic [3:0]  out_err;
   logic        out_valid;
   logic        out_ready;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   localparam logic [6:0] SEG_BAD = 7'b1001001;

   seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .seg       (seg),
      .dig_en    (dig_en),
      .out_bcd   (out_bcd),
      .out_err   (out_err),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  en;
      logic [6:0]  seg;
      logic        rdy;
      int          hold;
      logic        v;
      logic [15:0] bcd;
      logic [3:0]  err;
      logic        ovr;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic [3:0] en, input logic [6:0] s,
                      input logic rdy, input int hold, input logic v,
                      input logic [15:0] bcd, input logic [3:0] err, input logic ovr);
      vec_t t;
      t.rst = r; t.en = en; t.seg = s; t.rdy = rdy; t.hold = hold;
      t.v = v; t.bcd = bcd; t.err = err; t.ovr = ovr;
      vecs.push_back(t);
   endtask

   task automatic check(input string name, input int step, input logic [15:0] act,
                        input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
      end
   endtask

   task automatic check_outs(input int step, input logic v, input logic [15:0] bcd,
                             input logic [3:0] err, input logic ovr);
      check("out_valid", step, {15'd0, out_valid}, {15'd0, v});
      check("out_bcd",   step, out_bcd, bcd);
      check("out_err",   step, {12'd0, out_err}, {12'd0, err});
      check("overrun",   step, {15'd0, overrun}, {15'd0, ovr});
   endtask

   initial begin
      // frame 1: 4321, out_valid appears only after the 3rd sample of digit 3
      add(0, 4'b0001, SEG_1,     0, 3, 0, 16'h0000, 4'h0, 0);
      add(0, 4'b0010, SEG_2,     0, 3, 0, 16'h0000, 4'h0, 0);
      add(0, 4'b0100, SEG_3,     0, 3, 0, 16'h0000, 4'h0, 0);
      add(0, 4'b1000, SEG_4,     0, 2, 0, 16'h0000, 4'h0, 0);
      add(0, 4'b1000, SEG_4,     0, 1, 1, 16'h4321, 4'h0, 0);
      add(0, 4'b1000, SEG_4,     0, 3, 1, 16'h4321, 4'h0, 0);
      add(0, 4'b0000, SEG_BLANK, 1, 1, 0, 16'h4321, 4'h0, 0);
      // frame 2: bad pattern on digit 2, blank on digit 3; the digit 3
      // held above must not have been re-captured into this frame
      add(0, 4'b0100, SEG_BAD,   0, 3, 0, 16'h4321, 4'h0, 0);
      add(0, 4'b0010, SEG_5,     0, 3, 0, 16'h4321, 4'h0, 0);
      add(0, 4'b0001, SEG_1,     0, 3, 0, 16'h4321, 4'h0, 0);
      add(0, 4'b1000, SEG_BLANK, 0, 3, 1, 16'hAF51, 4'h4, 0);
      // frame 3 while frame 2 is unread; digit 0 glitches as 0 for 2 cycles
      add(0, 4'b0010, SEG_7,     0, 3, 1, 16'hAF51, 4'h4, 0);
      add(0, 4'b0100, SEG_8,     0, 3, 1, 16'hAF51, 4'h4, 0);
      add(0, 4'b1000, SEG_9,     0, 3, 1, 16'hAF51, 4'h4, 0);
      add(0, 4'b0001, SEG_0,     0, 2, 1, 16'hAF51, 4'h4, 0);
      add(0, 4'b0001, SEG_6,     0, 2, 1, 16'hAF51, 4'h4, 0);
      add(0, 4'b0001, SEG_6,     0, 1, 1, 16'hAF51, 4'h4, 1);
      add(0, 4'b0000, SEG_BLANK, 0, 1, 1, 16'hAF51, 4'h4, 0);
      add(0, 4'b0000, SEG_BLANK, 1, 1, 0, 16'hAF51, 4'h4, 0);
      // frame 4: a multi-hot strobe must not capture anything
      add(0, 4'b0001, SEG_9,     0, 3, 0, 16'hAF51, 4'h4, 0);
      add(0, 4'b0010, SEG_8,     0, 3, 0, 16'hAF51, 4'h4, 0);
      add(0, 4'b0100, SEG_7,     0, 3, 0, 16'hAF51, 4'h4, 0);
      add(0, 4'b1001, SEG_6,     0, 4, 0, 16'hAF51, 4'h4, 0);
      add(0, 4'b1000, SEG_6,     0, 3, 1, 16'h6789, 4'h0, 0);
      // frame 5 completes on the very cycle frame 4 is accepted
      add(0, 4'b0001, SEG_2,     0, 3, 1, 16'h6789, 4'h0, 0);
      add(0, 4'b0010, SEG_4,     0, 3, 1, 16'h6789, 4'h0, 0);
      add(0, 4'b0100, SEG_6,     0, 3, 1, 16'h6789, 4'h0, 0);
      add(0, 4'b1000, SEG_0,     0, 2, 1, 16'h6789, 4'h0, 0);
      add(0, 4'b1000, SEG_0,     1, 1, 1, 16'h0642, 4'h0, 0);
      add(0, 4'b0000, SEG_BLANK, 0, 1, 1, 16'h0642, 4'h0, 0);
      add(0, 4'b0000, SEG_BLANK, 1, 1, 0, 16'h0642, 4'h0, 0);
      // reset after two digits; next frame holds only post-reset digits
      add(0, 4'b0001, SEG_3,     0, 3, 0, 16'h0642, 4'h0, 0);
      add(0, 4'b0010, SEG_3,     0, 3, 0, 16'h0642, 4'h0, 0);
      add(1, 4'b0001, SEG_3,     0, 2, 0, 16'h0000, 4'h0, 0);
      add(0, 4'b0100, SEG_5,     0, 3, 0, 16'h0000, 4'h0, 0);
      add(0, 4'b1000, SEG_5,     0, 3, 0, 16'h0000, 4'h0, 0);
      add(0, 4'b0001, SEG_7,     0, 3, 0, 16'h0000, 4'h0, 0);
      add(0, 4'b0010, SEG_7,     0, 3, 1, 16'h5577, 4'h0, 0);

      // power-on reset with strobes idle
      rst = 1'b1; dig_en = '0; seg = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_outs(-1, 1'b0, 16'h0000, 4'h0, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check_outs(-2, 1'b0, 16'h0000, 4'h0, 1'b0);

      foreach (vecs[i]) begin
         rst       = vecs[i].rst;
         dig_en    = vecs[i].en;
         seg       = vecs[i].seg;
         out_ready = vecs[i].rdy;
         repeat (vecs[i].hold) @(negedge clk);
         check_outs(i, vecs[i].v, vecs[i].bcd, vecs[i].err, vecs[i].ovr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
